// File: rtl/fir_mac_engine.sv
// N-tap signed FIR with one time-shared multiplier, AXI-Lite configuration and AXI-Stream data path.
// Block-level control through ap_start / ap_done / ap_idle in the CTRL register.
module fir_mac_engine #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int NUM_TAPS    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    // AXI-Lite write
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    // AXI-Lite read
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    // AXI-Stream in
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    // AXI-Stream out
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready
);

    localparam int IW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [IW-1:0] LAST_TAP = IW'(NUM_TAPS - 1);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL     = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN      = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] ADDR_COEF     = pADDR_WIDTH'(32);
    localparam logic [pADDR_WIDTH-1:0] ADDR_COEF_END = pADDR_WIDTH'(32 + 4 * NUM_TAPS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_MAC   = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    function automatic logic coef_hit(input logic [pADDR_WIDTH-1:0] a);
        return (a >= ADDR_COEF) && (a < ADDR_COEF_END) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [IW-1:0] coef_index(input logic [pADDR_WIDTH-1:0] a);
        return IW'((a - ADDR_COEF) >> 2);
    endfunction

    logic [2:0]             state;
    logic [pDATA_WIDTH-1:0] coef    [NUM_TAPS];
    logic [pDATA_WIDTH-1:0] samples [NUM_TAPS];
    logic [IW-1:0]          head;
    logic [IW-1:0]          rd_idx;
    logic [IW-1:0]          tap;
    logic [pDATA_WIDTH-1:0] acc;
    logic [pDATA_WIDTH-1:0] data_length;
    logic [pDATA_WIDTH-1:0] count;
    logic                   ap_done;
    logic                   tlast_err;
    logic                   wr_ready;
    logic                   ar_en;

    logic                   idle;
    logic                   wr_fire;
    logic                   rd_fire;
    logic                   last_sample;
    logic                   done_set;
    logic                   start_ok;
    logic [pDATA_WIDTH-1:0] ctrl_word;
    logic [pDATA_WIDTH-1:0] rd_value;

    assign idle        = (state == S_IDLE);
    assign wr_fire     = wr_ready && awvalid && wvalid;
    assign rd_fire     = arvalid && arready;
    assign last_sample = ((count + pDATA_WIDTH'(1)) == data_length);
    assign done_set    = (state == S_OUT) && sm_tready && last_sample;
    assign start_ok    = wr_fire && (awaddr == ADDR_CTRL) && wdata[0] && idle
                         && (data_length != '0);

    assign awready   = wr_ready;
    assign wready    = wr_ready;
    // Held low for the first cycle out of reset so every output starts at zero.
    assign arready   = ar_en && !rvalid;
    assign ss_tready = (state == S_WAIT);
    assign sm_tvalid = (state == S_OUT);
    assign sm_tdata  = sm_tvalid ? acc : '0;
    assign sm_tlast  = sm_tvalid && last_sample;

    // A read racing the final output reports the status as it will be after that handshake.
    always_comb begin
        ctrl_word    = '0;
        ctrl_word[1] = ap_done || done_set;
        ctrl_word[2] = idle || done_set;
        ctrl_word[3] = tlast_err;
    end

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rd_value = '0;
        if (araddr == ADDR_CTRL)
            rd_value = ctrl_word;
        else if (araddr == ADDR_LEN)
            rd_value = data_length;
        else if (coef_hit(araddr))
            rd_value = coef[coef_index(araddr)];
    end

    // NOTE: the coefficient array is reset explicitly; a cleared map after reset is part of the contract.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ready    <= 1'b0;
            ar_en       <= 1'b0;
            rvalid      <= 1'b0;
            rdata       <= '0;
            data_length <= '0;
            ap_done     <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) coef[i] <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
            wr_ready <= awvalid && wvalid && !wr_ready;
            ar_en    <= 1'b1;

            if (wr_fire && idle) begin
                if (awaddr == ADDR_LEN)
                    data_length <= wdata;
                if (coef_hit(awaddr))
                    coef[coef_index(awaddr)] <= wdata;
            end

            if (rd_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_value;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end

            if (rd_fire && (araddr == ADDR_CTRL))
                ap_done <= 1'b0;
            else if (done_set)
                ap_done <= 1'b1;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state     <= S_IDLE;
            head      <= '0;
            rd_idx    <= '0;
            tap       <= '0;
            acc       <= '0;
            count     <= '0;
            tlast_err <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) samples[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state     <= S_CLEAR;
                        tap       <= '0;
                        count     <= '0;
                        tlast_err <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    samples[tap] <= '0;
                    if (tap == LAST_TAP) begin
                        state <= S_WAIT;
                        tap   <= '0;
                        head  <= '0;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ss_tvalid) begin
                        samples[head] <= ss_tdata;
                        rd_idx        <= head;
                        head          <= (head == LAST_TAP) ? '0 : head + 1'b1;
                        acc           <= '0;
                        tap           <= '0;
                        state         <= S_MAC;
                        if (ss_tlast != last_sample)
                            tlast_err <= 1'b1;
                    end
                end
                S_MAC: begin
                    // Walk backwards from the newest sample: x[n-k] pairs with h[k].
                    acc    <= acc + samples[rd_idx] * coef[tap];
                    rd_idx <= (rd_idx == '0) ? LAST_TAP : rd_idx - 1'b1;
                    if (tap == LAST_TAP)
                        state <= S_OUT;
                    else
                        tap <= tap + 1'b1;
                end
                S_OUT: begin
                    if (sm_tready) begin
                        count <= count + pDATA_WIDTH'(1);
                        state <= last_sample ? S_IDLE : S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: directed and randomized frames against a direct convolution model.
module tb_fir_mac_engine;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int N  = 11;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          awvalid = 1'b0, awready;
    logic [AW-1:0] awaddr = '0;
    logic          wvalid = 1'b0, wready;
    logic [DW-1:0] wdata = '0;
    logic          arvalid = 1'b0, arready;
    logic [AW-1:0] araddr = '0;
    logic          rvalid, rready = 1'b0;
    logic [DW-1:0] rdata;
    logic          ss_tvalid = 1'b0, ss_tlast = 1'b0, ss_tready;
    logic [DW-1:0] ss_tdata = '0;
    logic          sm_tvalid, sm_tlast, sm_tready = 1'b0;
    logic [DW-1:0] sm_tdata;

    fir_mac_engine #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .NUM_TAPS(N)) dut (
        .axis_clk(clk), .axis_rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] h_m [N];
    logic [31:0] x_m [64];
    logic [31:0] rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // y[n] = sum_k h[k] * x[n-k], samples before the frame are zero, 32-bit wraparound.
    function automatic logic [31:0] ref_y(input int n);
        logic [31:0] y = '0;
        for (int k = 0; k < N; k++)
            if (n - k >= 0) y = y + h_m[k] * x_m[n - k];
        return y;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axil_write(input logic [AW-1:0] a, input logic [31:0] d);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        for (int t = 0; t < TO && !awready; t++) tick();
        if (!awready) check("aw_ready_timeout", {31'b0, awready}, 32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axil_read(input logic [AW-1:0] a, output logic [31:0] d);
        d = 'x;
        araddr = a; arvalid = 1'b1;
        for (int t = 0; t < TO && !arready; t++) tick();
        if (!arready) check("ar_ready_timeout", {31'b0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        for (int t = 0; t < TO && !rvalid; t++) tick();
        if (!rvalid) begin
            check("rvalid_timeout", {31'b0, rvalid}, 32'd1);
            return;
        end
        d = rdata;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {25'b0, awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_sm_tdata"}, sm_tdata, 32'd0);
    endtask

    task automatic send_sample(input logic [31:0] x, input logic last);
        ss_tdata = x; ss_tlast = last; ss_tvalid = 1'b1;
        for (int t = 0; t < TO && !ss_tready; t++) tick();
        if (!ss_tready) check("ss_ready_timeout", {31'b0, ss_tready}, 32'd1);
        tick();
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
    endtask

    task automatic recv_output(input int n, input logic [31:0] exp, input logic exp_last,
                               input int hold, input logic chk_lat);
        int          t;
        logic [31:0] held;
        logic        stable;
        for (t = 0; t < TO && !sm_tvalid; t++) tick();
        if (!sm_tvalid) begin
            check("sm_valid_timeout", {31'b0, sm_tvalid}, 32'd1);
            return;
        end
        if (chk_lat) check("latency", t, N);
        if (hold > 0) begin
            held = sm_tdata;
            stable = 1'b1;
            repeat (hold) begin
                tick();
                if (sm_tdata !== held || !sm_tvalid || ss_tready) stable = 1'b0;
            end
            check("backpressure_stable", {31'b0, stable}, 32'd1);
        end
        check($sformatf("y[%0d]", n), sm_tdata, exp);
        check($sformatf("tlast[%0d]", n), {31'b0, sm_tlast}, {31'b0, exp_last});
        sm_tready = 1'b1;
        tick();
        sm_tready = 1'b0;
    endtask

    task automatic load_coefs();
        for (int k = 0; k < N; k++) axil_write(AW'(32 + 4 * k), h_m[k]);
    endtask

    // tl_pos: index of the sample carrying ss_tlast (-1 for none).
    task automatic run_frame(input int len, input int tl_pos, input int fixed_hold,
                             input int rand_hold, input int busy_at);
        int hold;
        axil_write(12'h010, len);
        axil_write(12'h000, 32'd1);
        for (int n = 0; n < len; n++) begin
            send_sample(x_m[n], n == tl_pos);
            hold = fixed_hold + ((rand_hold > 0) ? int'($urandom_range(rand_hold, 0)) : 0);
            recv_output(n, ref_y(n), n == len - 1, hold, n == 0);
            if (n == busy_at) begin
                axil_write(12'h020, 32'd99);
                axil_write(12'h010, len + 1);
                axil_read(12'h020, rd); check("busy_h0", rd, h_m[0]);
                axil_read(12'h010, rd); check("busy_len", rd, len);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick(); tick();
        axil_read(12'h000, rd); check("ctrl_after_reset", rd, 32'h4);
        axil_read(12'h020, rd); check("h0_after_reset", rd, 32'h0);

        // ap_start with data_length==0 is ignored.
        axil_write(12'h000, 32'd1);
        tick();
        check("len0_no_start", {31'b0, ss_tready}, 32'd0);
        axil_read(12'h000, rd); check("ctrl_len0", rd, 32'h4);
        axil_read(12'h008, rd); check("unmapped_08", rd, 32'h0);
        axil_read(AW'(32 + 4 * N), rd); check("unmapped_past_coef", rd, 32'h0);

        // Impulse response reproduces the coefficients.
        h_m = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
        load_coefs();
        axil_read(12'h024, rd); check("h1_readback", rd, 32'hFFFF_FFF6);
        for (int i = 0; i < 64; i++) x_m[i] = '0;
        x_m[0] = 32'd1;
        run_frame(11, 10, 0, 0, -1);
        axil_read(12'h000, rd); check("ctrl_done", rd, 32'h6);
        axil_read(12'h000, rd); check("ctrl_done_cleared", rd, 32'h4);

        // Step response, repeated to show the sample buffer is cleared.
        h_m = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0};
        load_coefs();
        x_m[0] = 1; x_m[1] = 1; x_m[2] = 1;
        check("step_model", ref_y(2), 32'd6);
        run_frame(3, 2, 0, 0, -1);
        axil_read(12'h000, rd); check("ctrl_step1", rd, 32'h6);
        run_frame(3, 2, 0, 0, -1);
        axil_read(12'h000, rd); check("ctrl_step2", rd, 32'h6);

        // Long backpressure on every output.
        for (int i = 0; i < 5; i++) x_m[i] = $urandom;
        run_frame(5, 4, 20, 0, -1);
        axil_read(12'h000, rd); check("ctrl_bp", rd, 32'h6);

        // Configuration writes while busy are dropped.
        run_frame(4, 3, 0, 0, 1);
        axil_read(12'h000, rd); check("ctrl_busy", rd, 32'h6);
        axil_read(12'h020, rd); check("h0_after_busy", rd, h_m[0]);
        axil_read(12'h010, rd); check("len_after_busy", rd, 32'd4);

        // Early and missing tlast set tlast_err; a clean frame clears it.
        run_frame(5, 1, 0, 0, -1);
        axil_read(12'h000, rd); check("ctrl_tlast_early", rd, 32'hE);
        axil_read(12'h000, rd); check("ctrl_tlast_sticky", rd, 32'hC);
        run_frame(2, 1, 0, 0, -1);
        axil_read(12'h000, rd); check("ctrl_tlast_cleared", rd, 32'h6);
        run_frame(3, -1, 0, 0, -1);
        axil_read(12'h000, rd); check("ctrl_tlast_missing", rd, 32'hE);

        // Randomized coefficients, lengths, samples and backpressure.
        for (int f = 0; f < 6; f++) begin
            int len;
            for (int k = 0; k < N; k++) h_m[k] = $urandom;
            load_coefs();
            len = int'($urandom_range(16, 1));
            for (int i = 0; i < len; i++) x_m[i] = $urandom;
            run_frame(len, len - 1, 0, 3, -1);
            axil_read(12'h000, rd); check($sformatf("ctrl_rand%0d", f), rd, 32'h6);
        end

        // Reset in the middle of the MAC phase.
        axil_write(12'h010, 32'd3);
        axil_write(12'h000, 32'd1);
        send_sample(32'd7, 1'b0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        tick();
        rst_n = 1'b1;
        tick(); tick();
        axil_read(12'h000, rd); check("ctrl_mid_reset", rd, 32'h4);
        axil_read(12'h02C, rd); check("h3_mid_reset", rd, 32'h0);
        axil_read(12'h010, rd); check("len_mid_reset", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
